// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
package fifo_rd_pkg;

    // Packer states: empty word, partial word, word presented downstream.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUT     = 2'd2
    } state_t;

    // Widest word the keep helper supports (bytes per word).
    localparam int MAX_BPW = 8;

    // One-hot keep bit for the byte lane selected by byte_cnt.
    function automatic logic [MAX_BPW-1:0] lane_mask(input logic [2:0] lane);
        lane_mask = MAX_BPW'(1) << lane;
    endfunction

endpackage

// File: rtl/rd_idle_timer.sv
// Saturating idle counter; expired flags TIMEOUT idle cycles (never for TIMEOUT=0).
module rd_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] idle_cnt;

    // Count idle cycles, holding at LIMIT so the count never wraps.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idle_cnt <= '0;
        end else if (inc && (idle_cnt != LIMIT)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT > 0) && (idle_cnt == LIMIT);

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a first-word-fall-through byte FIFO and packs BPW bytes little-endian
// into a valid/ready word stream, flushing partial words after an idle timeout.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE   = 8,
    parameter int BPW     = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic [DSIZE-1:0]     rdata,
    input  logic                 rempty,
    output logic                 rinc,
    output logic [DSIZE*BPW-1:0] out_data,
    output logic [BPW-1:0]       out_keep,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CNTW = $clog2(BPW);

    state_t          state, state_nxt;
    logic [CNTW-1:0] byte_cnt;
    logic            accept;
    logic            pop;
    logic            first;
    logic            last;
    logic            expired;
    logic [BPW-1:0]  lane_bit;

    assign out_valid = (state == OUT);
    assign accept    = !out_valid || out_ready;
    assign rinc      = !rempty && accept && !rrst;
    assign pop       = rinc;
    assign first     = (byte_cnt == '0);
    assign last      = (byte_cnt == CNTW'(BPW - 1));
    assign lane_bit  = BPW'(lane_mask(3'(byte_cnt)));

    // The timer only runs while a partial word waits for more bytes.
    rd_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (rclk),
        .rst     (rrst),
        .clear   (pop || (state != COLLECT)),
        .inc     (state == COLLECT),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a pop always wins over a coincident timeout.
    // NOTE: assigning state_nxt before the case keeps this block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (pop) begin
                    if (last) state_nxt = OUT;
                end else if (expired) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) state_nxt = pop ? COLLECT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane write on each pop; the first byte of a word clears stale lanes.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_data <= '0;
            out_keep <= '0;
            byte_cnt <= '0;
        end else if (pop) begin
            for (int i = 0; i < BPW; i++) begin
                if (CNTW'(i) == byte_cnt) begin
                    out_data[i*DSIZE +: DSIZE] <= rdata;
                end else if (first) begin
                    out_data[i*DSIZE +: DSIZE] <= '0;
                end
            end
            out_keep <= (first ? '0 : out_keep) | lane_bit;
            // BPW is a power of two, so the increment wraps to lane 0.
            byte_cnt <= byte_cnt + 1'b1;
        end else if ((state == COLLECT) && expired) begin
            byte_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench: a queue models the FWFT FIFO, a scoreboard holds expected words.
module tb_fifo_rd_packer;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } word_t;

    logic        clk = 1'b0;
    logic        rrst;
    logic [7:0]  rdata, rdata2;
    logic        rempty, rempty2;
    logic        rinc, rinc2;
    logic [31:0] out_data, out_data2;
    logic [3:0]  out_keep, out_keep2;
    logic        out_valid, out_valid2;
    logic        out_ready;

    logic [7:0]  fq[$];
    logic [7:0]  fq2[$];
    word_t       exp_q[$];
    vec_t        vecs[4];

    int          checks = 0;
    int          failures = 0;
    logic        s_rinc, s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        seen_valid2;

    always #5 clk = ~clk;

    fifo_rd_packer #(.DSIZE(8), .BPW(4), .TIMEOUT(16)) dut (
        .rclk      (clk),
        .rrst      (rrst),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    fifo_rd_packer #(.DSIZE(8), .BPW(4), .TIMEOUT(0)) dut_nt (
        .rclk      (clk),
        .rrst      (rrst),
        .rdata     (rdata2),
        .rempty    (rempty2),
        .rinc      (rinc2),
        .out_data  (out_data2),
        .out_keep  (out_keep2),
        .out_valid (out_valid2),
        .out_ready (1'b1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: present FIFO head, sample just after the falling edge,
    // score any handshake, then retire popped bytes at the rising edge.
    task automatic cycle();
        word_t w;
        logic  pop, pop2;
        rempty  = (fq.size() == 0);
        rdata   = rempty ? 8'h00 : fq[0];
        rempty2 = (fq2.size() == 0);
        rdata2  = rempty2 ? 8'h00 : fq2[0];
        #1;
        pop     = rinc;
        pop2    = rinc2;
        s_rinc  = rinc;
        s_valid = out_valid;
        s_data  = out_data;
        s_keep  = out_keep;
        if (out_valid2) seen_valid2 = 1'b1;
        if (!rrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {32'h0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("word_data", 64'(out_data), 64'(w.data));
                check("word_keep", 64'(out_keep), 64'(w.keep));
            end
        end
        @(posedge clk);
        if (pop && fq.size() != 0) void'(fq.pop_front());
        if (pop2 && fq2.size() != 0) void'(fq2.pop_front());
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pops;
        int   n;
        logic any_valid;

        rrst        = 1'b1;
        out_ready   = 1'b1;
        rdata       = 8'h00;
        rempty      = 1'b1;
        rdata2      = 8'h00;
        rempty2     = 1'b1;
        seen_valid2 = 1'b0;
        @(negedge clk);

        // Reset state
        cycle();
        cycle();
        check("rst_valid", 64'(s_valid), 64'd0);
        check("rst_data",  64'(s_data),  64'd0);
        check("rst_keep",  64'(s_keep),  64'd0);
        check("rst_rinc",  64'(s_rinc),  64'd0);
        rrst = 1'b0;

        // Table-driven steady stream, out_ready held high
        vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 4'hF};
        vecs[1] = '{8'h05, 8'h06, 8'h07, 8'h08, 32'h08070605, 4'hF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF, 4'hF};
        vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5, 4'hF};
        for (int i = 0; i < 4; i++) begin
            fq.push_back(vecs[i].b0);
            fq.push_back(vecs[i].b1);
            fq.push_back(vecs[i].b2);
            fq.push_back(vecs[i].b3);
            exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_keep});
        end
        pops = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (s_rinc) pops++;
        end
        check("stream_no_gaps", 64'(pops), 64'd16);
        drain("stream_drain", 10);

        // Back-pressure after the first word
        for (int b = 1; b <= 8; b++) fq.push_back(8'(b));
        exp_q.push_back('{32'h04030201, 4'hF});
        exp_q.push_back('{32'h08070605, 4'hF});
        repeat (4) cycle();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("bp_valid", 64'(s_valid), 64'd1);
            check("bp_hold",  64'(s_data),  64'h04030201);
            check("bp_rinc",  64'(s_rinc),  64'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_pop", 64'(s_rinc), 64'd1);
        cycle();
        check("bp_next_lane0", 64'(s_data), 64'h00000005);
        check("bp_next_keep",  64'(s_keep), 64'h1);
        drain("bp_drain", 20);
        repeat (2) cycle();

        // Timeout flush of a 2-byte partial word
        fq.push_back(8'hAA);
        fq.push_back(8'hBB);
        exp_q.push_back('{32'h0000BBAA, 4'b0011});
        cycle();
        cycle();
        // Sample n reflects n-1 edges after the last pop edge: 16 edges -> n=17.
        n = 1;
        cycle();
        while (!s_valid && n < 40) begin
            cycle();
            n++;
        end
        check("flush_delay", 64'(n), 64'd17);
        check("flush_keep",  64'(s_keep), 64'b0011);
        drain("flush_drain", 5);
        repeat (2) cycle();

        // Pop arriving at idle_cnt=15 beats the timeout
        fq.push_back(8'h21);
        fq.push_back(8'h22);
        exp_q.push_back('{32'hDDCC2221, 4'hF});
        cycle();
        cycle();
        any_valid = 1'b0;
        repeat (15) begin
            cycle();
            if (s_valid) any_valid = 1'b1;
        end
        fq.push_back(8'hCC);
        cycle();
        if (s_valid) any_valid = 1'b1;
        check("pw_pop", 64'(s_rinc), 64'd1);
        repeat (3) begin
            cycle();
            if (s_valid) any_valid = 1'b1;
        end
        check("pw_no_flush", 64'(any_valid), 64'd0);
        check("pw_lane2",    64'(s_data[23:16]), 64'hCC);
        check("pw_keep",     64'(s_keep), 64'b0111);
        fq.push_back(8'hDD);
        drain("pw_drain", 10);
        repeat (2) cycle();

        // Reset in the middle of a word discards it
        fq.push_back(8'h31);
        fq.push_back(8'h32);
        fq.push_back(8'h33);
        repeat (3) cycle();
        for (int b = 8'h11; b <= 8'h14; b++) fq.push_back(8'(b));
        exp_q.push_back('{32'h14131211, 4'hF});
        rrst = 1'b1;
        cycle();
        check("mid_rst_rinc", 64'(s_rinc), 64'd0);
        cycle();
        check("mid_rst_valid", 64'(s_valid), 64'd0);
        check("mid_rst_data",  64'(s_data),  64'd0);
        check("mid_rst_keep",  64'(s_keep),  64'd0);
        rrst = 1'b0;
        drain("mid_rst_drain", 20);

        // TIMEOUT=0 instance holds a lone byte indefinitely
        seen_valid2 = 1'b0;
        fq2.push_back(8'h77);
        repeat (200) cycle();
        check("nt_never_valid", 64'(seen_valid2), 64'd0);
        check("nt_popped",      64'(fq2.size()), 64'd0);
        check("nt_data",        64'(out_data2), 64'h00000077);
        check("nt_keep",        64'(out_keep2), 64'b0001);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
